f1_timing_ctrl: RTL and testbench
=================================

F1_TIMING_CTRL -- requirements
Module: f1_timing_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, width of the period input, tick counter and reaction counter.
REQ-002 Parameter LFSR_SEED, default 7'h01, nonzero reset value of the delay LFSR.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_seq  input  1  light-sequence phase request from the start-light FSM.
REQ-006 cmd_delay  input  1  random-hold phase request from the start-light FSM.
REQ-007 n_period  input  WIDTH  tick period in clk cycles; 0 treated as 1.
REQ-008 btn  input  1  player button, already synchronous to clk.
REQ-009 tick  output  1  one-cycle advance strobe, drives the start-light FSM enable.
REQ-010 lights_out  output  1  one-cycle pulse when the random hold expires.
REQ-011 react_valid  output  1  one-cycle pulse; react_time is valid in the same cycle.
REQ-012 react_time  output  WIDTH  clk cycles from lights_out to the btn rising edge, saturating.
REQ-013 jump_start  output  1  one-cycle pulse on a premature press.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, SEQ, DELAY, REACT.
REQ-016 IDLE -> DELAY when cmd_delay=1; otherwise IDLE -> SEQ when cmd_seq=1; cmd_delay has priority when both are high.
REQ-017 In SEQ the tick counter SHALL load max(n_period,1)-1 on entry, decrement each cycle, and assert tick for one cycle at 0 while reloading; the first tick comes max(n_period,1) cycles after entry.
REQ-018 SEQ -> DELAY when cmd_delay=1; SEQ -> IDLE when cmd_seq=0 and cmd_delay=0.
REQ-019 Delay LFSR: 7-bit Fibonacci, taps x^7+x^6+1, free-running every cycle from reset, never zero.
REQ-020 On DELAY entry the LFSR value L (1..127) SHALL be captured; the hold lasts L*max(n_period,1) cycles; tick SHALL be held low during the hold.
REQ-021 At hold expiry tick and lights_out SHALL assert together for exactly one cycle, and the block SHALL enter REACT with the reaction counter at 0.
REQ-022 In REACT the counter SHALL increment every cycle and saturate at 2^WIDTH-1 without wrapping.
REQ-023 A btn rising edge (btn=1 with registered btn=0) in REACT SHALL pulse react_valid with react_time = counter value, then go to IDLE; if btn is already high at REACT entry, a release and re-press is required.
REQ-024 react_time SHALL hold its last reported value until the next react_valid.
REQ-025 cmd_seq and cmd_delay SHALL be ignored in DELAY and REACT.
REQ-026 n_period SHALL be sampled at each counter reload; changes mid-count take effect at the next reload.

Reset
REQ-027 On rst the block SHALL enter IDLE immediately, independent of clk, including mid-operation.
REQ-028 On rst tick, lights_out, react_valid, jump_start and busy SHALL be 0, react_time SHALL be 0, all counters SHALL be 0, and the LFSR SHALL be LFSR_SEED.

Configuration
REQ-029 Macro F1_JUMP_START_EN: when defined, a btn rising edge in SEQ or DELAY SHALL pulse jump_start, suppress tick and lights_out in that cycle, and return to IDLE.
REQ-030 Without F1_JUMP_START_EN, jump_start SHALL be tied 0 and btn SHALL be ignored outside REACT.

Structure
REQ-031 Package f1_pkg SHALL hold the state enum, the LFSR width (7), the tap mask, and the default WIDTH.
REQ-032 The LFSR SHALL be a sub-module lfsr7 with ports clk, rst, and a 7-bit q; the counters and the FSM stay in f1_timing_ctrl.

Verification
REQ-033 n_period=4, cmd_seq=1 from IDLE -> tick on cycles 4, 8, 12 after SEQ entry, low otherwise.
REQ-034 n_period=0, cmd_seq=1 -> tick asserted every cycle.
REQ-035 n_period=3, cmd_delay=1 with captured L=5 -> tick and lights_out coincide exactly 15 cycles after DELAY entry, with no tick before.
REQ-036 btn rises 37 cycles after lights_out -> react_valid for one cycle, react_time=37, busy=0 next cycle.
REQ-037 WIDTH=4, no press for 20 cycles after lights_out -> counter holds at 15; a later press reports 15.
REQ-038 Mid-run checks:
- rst asserted mid-DELAY -> all outputs 0 asynchronously and IDLE.
- With F1_JUMP_START_EN, btn rising edge in SEQ -> jump_start pulse and no further tick.

Source files
------------

// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding, delay LFSR constants and default width for the F1 reaction timer
package f1_pkg;
  typedef enum logic [1:0] {IDLE, SEQ, DELAY, REACT} state_t;
  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/f1_timing_ctrl_if.sv
// f1_timing_ctrl_if: command, button and result signals between the start-light FSM and the timing block
interface f1_timing_ctrl_if import f1_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic cmd_seq, cmd_delay, btn, tick, lights_out, react_valid, jump_start, busy;
  logic [WIDTH-1:0] n_period, react_time;
  modport master(
    output cmd_seq, cmd_delay, n_period, btn,
    input tick, lights_out, react_valid, react_time, jump_start, busy
  );
  modport slave(
    input cmd_seq, cmd_delay, n_period, btn,
    output tick, lights_out, react_valid, react_time, jump_start, busy
  );
endinterface

// File: rtl/f1_timing_ctrl_lfsr7.sv
// lfsr7: free-running 7-bit Fibonacci LFSR (x^7+x^6+1), maximal length so it never reaches zero
module lfsr7 import f1_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= SEED;
    else q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/f1_timing_ctrl.sv
// f1_timing_ctrl: tick generator, random hold and reaction timer; F1_JUMP_START_EN enables jump-start detection
module f1_timing_ctrl import f1_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h01
) (
  input logic clk,
  input logic rst,
  f1_timing_ctrl_if.slave bus
);
  state_t state;
  logic [WIDTH-1:0] cnt, rcnt, time_r, per_m1;
  logic [LFSR_W-1:0] dcnt, lq;
  logic btn_q, tick_r, lights_r, valid_r, busy_r, rise, jump;
  lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lq));
  assign per_m1 = (bus.n_period == '0) ? '0 : bus.n_period - WIDTH'(1);
  assign rise = bus.btn & ~btn_q;
`ifdef F1_JUMP_START_EN
  logic js_r;
  assign jump = rise && (state == SEQ || state == DELAY);
  always_ff @(posedge clk or posedge rst)
    if (rst) js_r <= 1'b0;
    else js_r <= jump;
  assign bus.jump_start = js_r;
`else
  assign jump = 1'b0;
  assign bus.jump_start = 1'b0;
`endif
  // the hold counts whole periods: dcnt counts down once per period expiry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rcnt <= '0;
      dcnt <= '0;
      btn_q <= 1'b0;
      tick_r <= 1'b0;
      lights_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r <= 1'b0;
      time_r <= '0;
    end else begin
      btn_q <= bus.btn;
      tick_r <= 1'b0;
      lights_r <= 1'b0;
      valid_r <= 1'b0;
      case (state)
        IDLE:
          if (bus.cmd_delay) begin
            state <= DELAY;
            cnt <= per_m1;
            dcnt <= lq;
            busy_r <= 1'b1;
          end else if (bus.cmd_seq) begin
            state <= SEQ;
            cnt <= per_m1;
            busy_r <= 1'b1;
          end
        SEQ:
          if (jump) begin
            state <= IDLE;
            busy_r <= 1'b0;
          end else if (bus.cmd_delay) begin
            state <= DELAY;
            cnt <= per_m1;
            dcnt <= lq;
          end else if (!bus.cmd_seq) begin
            state <= IDLE;
            busy_r <= 1'b0;
          end else if (cnt == '0) begin
            tick_r <= 1'b1;
            cnt <= per_m1;
          end else cnt <= cnt - WIDTH'(1);
        DELAY:
          if (jump) begin
            state <= IDLE;
            busy_r <= 1'b0;
          end else if (cnt == '0) begin
            cnt <= per_m1;
            if (dcnt == LFSR_W'(1)) begin
              tick_r <= 1'b1;
              lights_r <= 1'b1;
              rcnt <= '0;
              state <= REACT;
            end else dcnt <= dcnt - LFSR_W'(1);
          end else cnt <= cnt - WIDTH'(1);
        REACT:
          if (rise) begin
            valid_r <= 1'b1;
            time_r <= rcnt;
            state <= IDLE;
            busy_r <= 1'b0;
          end else if (!(&rcnt)) rcnt <= rcnt + WIDTH'(1);
        default: state <= IDLE;
      endcase
    end
  assign bus.tick = tick_r;
  assign bus.lights_out = lights_r;
  assign bus.react_valid = valid_r;
  assign bus.react_time = time_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_f1_timing_ctrl.sv
// tb_f1_timing_ctrl: directed vector table plus multi-cycle sequences for the F1 timing block
module tb_f1_timing_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  f1_timing_ctrl_if #(.WIDTH(16)) b();
  f1_timing_ctrl_if #(.WIDTH(4)) b4();
  f1_timing_ctrl #(.WIDTH(16), .LFSR_SEED(7'h01)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  f1_timing_ctrl #(.WIDTH(4), .LFSR_SEED(7'h01)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] m;
  always @(posedge clk or posedge rst)
    if (rst) m <= 7'h01;
    else m <= {m[5:0], m[6] ^ m[5]};
  typedef struct {
    logic seq;
    logic dly;
    logic [15:0] np;
    logic exp_tick;
    logic exp_busy;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic s, input logic d, input logic [15:0] np, input logic et, input logic eb);
    vec_t e;
    e.seq = s; e.dly = d; e.np = np; e.exp_tick = et; e.exp_busy = eb;
    v.push_back(e);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int first, w, vc, nt;
    b.cmd_seq = 0; b.cmd_delay = 0; b.n_period = '0; b.btn = 0;
    b4.cmd_seq = 0; b4.cmd_delay = 0; b4.n_period = '0; b4.btn = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tick", b.tick, 0);
    chk("rst_lights", b.lights_out, 0);
    chk("rst_valid", b.react_valid, 0);
    chk("rst_time", b.react_time, 0);
    chk("rst_jump", b.jump_start, 0);
    chk("rst_busy", b.busy, 0);
    rst = 1'b0;
    add(1, 0, 4, 0, 1);
    for (int i = 1; i <= 12; i++) add(1, 0, 4, (i % 4) == 0, 1);
    add(0, 0, 4, 0, 0);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 1);
    add(1, 0, 0, 1, 1);
    add(1, 0, 2, 1, 1);
    add(1, 0, 2, 0, 1);
    add(1, 0, 2, 1, 1);
    add(0, 0, 2, 0, 0);
    foreach (v[i]) begin
      @(negedge clk);
      b.cmd_seq = v[i].seq; b.cmd_delay = v[i].dly; b.n_period = v[i].np;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tick", i), b.tick, v[i].exp_tick);
      chk($sformatf("vec%0d_busy", i), b.busy, v[i].exp_busy);
    end
    // random hold with captured L=5 and period 3
    b.n_period = 3;
    w = 0;
    @(negedge clk);
    while (m !== 7'd5 && w < 300) begin @(negedge clk); w++; end
    chk("lfsr_reaches_5", w < 300, 1);
    b.cmd_delay = 1;
    @(posedge clk); #1;
    b.cmd_delay = 0;
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(posedge clk); #1;
      if (b.tick) first = k;
    end
    chk("delay_first_tick", first, 15);
    chk("delay_lights", b.lights_out, 1);
    chk("delay_busy", b.busy, 1);
    @(posedge clk); #1;
    chk("lights_one_cycle", b.lights_out, 0);
    chk("tick_one_cycle", b.tick, 0);
    repeat (36) @(posedge clk);
    @(negedge clk); b.btn = 1;
    @(posedge clk); #1;
    chk("react_valid", b.react_valid, 1);
    chk("react_time", b.react_time, 37);
    chk("react_busy", b.busy, 0);
    @(negedge clk); b.btn = 0;
    @(posedge clk); #1;
    chk("react_valid_pulse", b.react_valid, 0);
    chk("react_time_hold", b.react_time, 37);
    chk("react_busy_next", b.busy, 0);
    // saturation on the 4-bit instance, button already held at REACT entry
    @(negedge clk); b4.n_period = 1; b4.btn = 1;
    @(negedge clk); b4.cmd_delay = 1;
    @(posedge clk); #1;
    b4.cmd_delay = 0;
    w = 0;
    do begin @(posedge clk); #1; w++; end while (!b4.lights_out && w < 200);
    chk("w4_lights_seen", b4.lights_out, 1);
    vc = 0;
    repeat (20) begin @(posedge clk); #1; vc += int'(b4.react_valid); end
    chk("w4_held_btn_ignored", vc, 0);
    @(negedge clk); b4.btn = 0;
    @(negedge clk); b4.btn = 1;
    @(posedge clk); #1;
    chk("w4_valid", b4.react_valid, 1);
    chk("w4_sat_time", b4.react_time, 15);
    @(negedge clk); b4.btn = 0;
    // asynchronous reset in the middle of a long hold
    @(negedge clk); b.n_period = 100; b.cmd_delay = 1;
    @(posedge clk); #1;
    b.cmd_delay = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_delay_busy", b.busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", b.busy, 0);
    chk("arst_tick", b.tick, 0);
    chk("arst_lights", b.lights_out, 0);
    chk("arst_valid", b.react_valid, 0);
    chk("arst_time", b.react_time, 0);
    chk("arst_jump", b.jump_start, 0);
    @(negedge clk); rst = 1'b0;
    // button press during the light sequence
    @(negedge clk); b.n_period = 2; b.cmd_seq = 1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk); b.btn = 1;
    @(posedge clk); #1;
`ifdef F1_JUMP_START_EN
    chk("js_pulse", b.jump_start, 1);
    chk("js_tick_suppressed", b.tick, 0);
    chk("js_busy", b.busy, 0);
    b.cmd_seq = 0;
    nt = 0;
    repeat (4) begin @(posedge clk); #1; nt += int'(b.tick); end
    chk("js_no_more_ticks", nt, 0);
    chk("js_pulse_end", b.jump_start, 0);
`else
    chk("nojs_jump_low", b.jump_start, 0);
    chk("nojs_tick", b.tick, 1);
    chk("nojs_busy", b.busy, 1);
    nt = 0;
    repeat (4) begin @(posedge clk); #1; nt += int'(b.tick); end
    chk("nojs_ticks_continue", nt, 2);
    b.cmd_seq = 0;
`endif
    b.btn = 0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
